// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage RV32 core.
//
// Computes the ALU result from the operands, opcode and destination fields held in
// the ID/EX register. It registers {wd, wa, we} towards the MEM stage.
//
// Configuration macro: EX_MUL_EN
//   defined   - MUL/MULH/MULHSU/MULHU run on an iterative 32-step shift-add unit.
//               The upstream pipeline is held with stall while the unit is busy.
//               DIV/REM encodings return 0.
//   undefined - ex_m is ignored, stall is tied to 0 and no FSM is built.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst     in   1  asynchronous active-low reset
//   ex_t    in   7  opcode
//   ex_st   in   3  funct3
//   ex_sst  in   1  funct7[5] (SUB/SRA select)
//   ex_m    in   1  funct7[0] (RV32M select)
//   ex_n1   in  32  operand 1
//   ex_n2   in  32  operand 2 (register or immediate)
//   ex_wa   in   5  destination register
//   ex_we   in   1  destination write enable
//   mem_wd  out 32  registered result
//   mem_wa  out  5  registered destination
//   mem_we  out  1  registered write enable
//   stall   out  1  combinational hold request to upstream
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  ex_t,
   input  logic [2:0]  ex_st,
   input  logic        ex_sst,
   input  logic        ex_m,
   input  logic [31:0] ex_n1,
   input  logic [31:0] ex_n2,
   input  logic [4:0]  ex_wa,
   input  logic        ex_we,
   output logic [31:0] mem_wd,
   output logic [4:0]  mem_wa,
   output logic        mem_we,
   output logic        stall
);

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcLui   = 7'b0110111;

   logic [31:0] alu_res;
   logic [31:0] wd_d;
   logic [4:0]  wa_d;
   logic        we_d;

   // Base ALU. Non-ALU opcodes fall through to n1 + n2 (addresses, link values).
   always_comb begin
      alu_res = ex_n1 + ex_n2;
      if (ex_t == OpcOp || ex_t == OpcOpImm) begin
         unique case (ex_st)
            3'b000: alu_res = (ex_t == OpcOp && ex_sst) ? ex_n1 - ex_n2 : ex_n1 + ex_n2;
            3'b001: alu_res = ex_n1 << ex_n2[4:0];
            3'b010: alu_res = {31'd0, $signed(ex_n1) < $signed(ex_n2)};
            3'b011: alu_res = {31'd0, ex_n1 < ex_n2};
            3'b100: alu_res = ex_n1 ^ ex_n2;
            3'b101: alu_res = ex_sst ? 32'($signed(ex_n1) >>> ex_n2[4:0])
                                     : ex_n1 >> ex_n2[4:0];
            3'b110: alu_res = ex_n1 | ex_n2;
            3'b111: alu_res = ex_n1 & ex_n2;
            default: alu_res = ex_n1 + ex_n2;
         endcase
      end else if (ex_t == OpcLui) begin
         alu_res = ex_n2;
      end
   end

`ifdef EX_MUL_EN
   typedef enum logic {StIdle, StBusy} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic        neg_q, neg_d;
   logic        hi_q, hi_d;
   logic [4:0]  lwa_q, lwa_d;
   logic        lwe_q, lwe_d;

   logic        mul_trig;
   logic        div_op;
   logic        s1, s2;
   logic [63:0] addend;
   logic [63:0] acc_sum;
   logic [63:0] prod;

   assign mul_trig = (ex_t == OpcOp) && ex_m && !ex_st[2];
   assign div_op   = (ex_t == OpcOp) && ex_m && ex_st[2];

   // MULH (001): both signed; MULHSU (010): only n1 signed.
   assign s1 = (ex_st[1:0] == 2'b01 || ex_st[1:0] == 2'b10) && ex_n1[31];
   assign s2 = (ex_st[1:0] == 2'b01) && ex_n2[31];

   assign addend  = mplier_q[cnt_q] ? ({32'd0, mcand_q} << cnt_q) : 64'd0;
   assign acc_sum = acc_q + addend;
   assign prod    = neg_q ? -acc_sum : acc_sum;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lwa_d    = lwa_q;
      lwe_d    = lwe_q;
      wd_d     = alu_res;
      wa_d     = ex_wa;
      we_d     = ex_we;
      unique case (state_q)
         StIdle: begin
            if (mul_trig) begin
               mcand_d  = s1 ? -ex_n1 : ex_n1;
               mplier_d = s2 ? -ex_n2 : ex_n2;
               neg_d    = s1 ^ s2;
               hi_d     = (ex_st[1:0] != 2'b00);
               lwa_d    = ex_wa;
               lwe_d    = ex_we;
               acc_d    = 64'd0;
               cnt_d    = 5'd0;
               state_d  = StBusy;
               wd_d     = 32'd0;
               wa_d     = 5'd0;
               we_d     = 1'b0;
            end else if (div_op) begin
               wd_d = 32'd0;
            end
         end
         StBusy: begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 5'd1;
            wd_d  = 32'd0;
            wa_d  = 5'd0;
            we_d  = 1'b0;
            if (cnt_q == 5'd31) begin
               state_d = StIdle;
               wd_d    = hi_q ? prod[63:32] : prod[31:0];
               wa_d    = lwa_q;
               we_d    = lwe_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= 5'd0;
         acc_q    <= 64'd0;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
         lwa_q    <= 5'd0;
         lwe_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lwa_q    <= lwa_d;
         lwe_q    <= lwe_d;
      end
   end

   // Gated by rst so a held trigger cannot raise stall while in reset.
   assign stall = rst && (((state_q == StIdle) && mul_trig) ||
                          ((state_q == StBusy) && (cnt_q != 5'd31)));
`else
   logic unused_m;

   assign unused_m = ex_m;
   assign wd_d     = alu_res;
   assign wa_d     = ex_wa;
   assign we_d     = ex_we;
   assign stall    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_wd <= 32'd0;
         mem_wa <= 5'd0;
         mem_we <= 1'b0;
      end else begin
         mem_wd <= wd_d;
         mem_wa <= wa_d;
         mem_we <= we_d;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

   localparam logic [6:0] OP    = 7'b0110011;
   localparam logic [6:0] OPIMM = 7'b0010011;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] JALR  = 7'b1100111;
   localparam logic [6:0] LOAD  = 7'b0000011;

   logic        clk;
   logic        rst;
   logic [6:0]  ex_t;
   logic [2:0]  ex_st;
   logic        ex_sst;
   logic        ex_m;
   logic [31:0] ex_n1;
   logic [31:0] ex_n2;
   logic [4:0]  ex_wa;
   logic        ex_we;
   logic [31:0] mem_wd;
   logic [4:0]  mem_wa;
   logic        mem_we;
   logic        stall;

   int checks = 0;
   int errors = 0;

   ex_stage dut (
      .clk    (clk),
      .rst    (rst),
      .ex_t   (ex_t),
      .ex_st  (ex_st),
      .ex_sst (ex_sst),
      .ex_m   (ex_m),
      .ex_n1  (ex_n1),
      .ex_n2  (ex_n2),
      .ex_wa  (ex_wa),
      .ex_we  (ex_we),
      .mem_wd (mem_wd),
      .mem_wa (mem_wa),
      .mem_we (mem_we),
      .stall  (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model from the instruction semantics, using 64-bit integer arithmetic.
   function automatic logic [31:0] model(input logic [6:0] t, input logic [2:0] f3,
                                         input logic sst, input logic m,
                                         input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned pw = 64'd1 << b[4:0];
      longint          q;
      logic [63:0]     x;
      logic [63:0]     y;
      logic [63:0]     p;
      logic [31:0]     r;
      r = a + b;
`ifdef EX_MUL_EN
      if (t == OP && m) begin
         if (f3[2]) return 32'd0;
         x = (f3 == 3'd1 || f3 == 3'd2) ? sa : ua;
         y = (f3 == 3'd1) ? sb : ub;
         p = x * y;
         return (f3 == 3'd0) ? p[31:0] : p[63:32];
      end
`else
      if (m) r = a + b;
`endif
      if (t == OP || t == OPIMM) begin
         case (f3)
            3'd0: r = (t == OP && sst) ? a - b : a + b;
            3'd1: begin p = ua * pw; r = p[31:0]; end
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
               if (sst) begin
                  q = sa / longint'(pw);
                  if (sa < 0 && q * longint'(pw) != sa) q = q - 1;
                  p = q;
                  r = p[31:0];
               end else begin
                  p = ua / pw;
                  r = p[31:0];
               end
            end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end else if (t == LUI) begin
         r = b;
      end
      return r;
   endfunction

   task automatic set_in(input logic [6:0] t, input logic [2:0] f3, input logic sst,
                         input logic m, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we);
      ex_t = t; ex_st = f3; ex_sst = sst; ex_m = m;
      ex_n1 = a; ex_n2 = b; ex_wa = wa; ex_we = we;
   endtask

   // Entered 1 ns after a rising edge; leaves 1 ns after the next one.
   task automatic run_alu(input string tag, input logic [6:0] t, input logic [2:0] f3,
                          input logic sst, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa, input logic we,
                          input logic [31:0] exp);
      set_in(t, f3, sst, m, a, b, wa, we);
      #1;
      check({tag, "_stall"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      check({tag, "_wd"}, mem_wd, exp);
      check({tag, "_wa"}, 32'(mem_wa), 32'(wa));
      check({tag, "_we"}, 32'(mem_we), 32'(we));
   endtask

`ifdef EX_MUL_EN
   // Presents a multiply in cycle 0, holds it through cycle 32, checks cycle 33.
   task automatic run_mul(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa, input logic we,
                          input logic [31:0] exp);
      int   stall_hi;
      int   bubble_bad;
      logic stall32;
      set_in(OP, f3, 1'b0, 1'b1, a, b, wa, we);
      stall_hi   = 0;
      bubble_bad = 0;
      stall32    = 1'b1;
      for (int cyc = 0; cyc <= 32; cyc++) begin
         #1;
         if (cyc <= 31 && stall === 1'b1) stall_hi++;
         if (cyc == 32) stall32 = stall;
         if (cyc >= 1 && (mem_we !== 1'b0 || mem_wd !== 32'd0)) bubble_bad++;
         @(posedge clk); #1;
      end
      check({tag, "_stall_cycles"}, 32'(stall_hi), 32'd32);
      check({tag, "_stall_c32"}, 32'(stall32), 32'd0);
      check({tag, "_bubbles"}, 32'(bubble_bad), 32'd0);
      check({tag, "_wd"}, mem_wd, exp);
      check({tag, "_wa"}, 32'(mem_wa), 32'(wa));
      check({tag, "_we"}, 32'(mem_we), 32'(we));
   endtask
`endif

   initial begin
      logic [6:0]  rt;
      logic [2:0]  rf3;
      logic        rsst;
      logic        rm;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [4:0]  rwa;
      logic        rwe;
      logic [6:0]  opc [5];
      opc[0] = OP; opc[1] = OPIMM; opc[2] = LUI; opc[3] = JALR; opc[4] = LOAD;

      // Reset held while inputs toggle, including a multiply trigger.
      rst = 1'b0;
      set_in(OP, 3'd0, 1'b0, 1'b1, 32'd3, 32'd4, 5'd1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #2;
         check("rst_wd", mem_wd, 32'd0);
         check("rst_wa", 32'(mem_wa), 32'd0);
         check("rst_we", 32'(mem_we), 32'd0);
         check("rst_stall", 32'(stall), 32'd0);
         @(posedge clk); #1;
         set_in(opc[$urandom_range(0, 4)], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom, 5'($urandom), 1'b1);
      end
      rst = 1'b1;
      run_alu("add_after_rst", OP, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 5'd9, 1'b1, 32'd12);

      // Directed ALU sweep.
      run_alu("sub", OP, 3'd0, 1'b1, 1'b0, 32'd3, 32'd5, 5'd2, 1'b1, 32'hFFFF_FFFE);
      run_alu("sra", OP, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 5'd3, 1'b1, 32'hF800_0000);
      run_alu("srl", OP, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 5'd4, 1'b0, 32'h0800_0000);
      run_alu("slt", OP, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 32'd1);
      run_alu("sltu", OP, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 32'd0);
      run_alu("addi_sst", OPIMM, 3'd0, 1'b1, 1'b0, 32'd10, 32'd3, 5'd7, 1'b1, 32'd13);
      run_alu("lui", LUI, 3'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5000, 5'd0, 1'b1,
              32'h1234_5000);

`ifndef EX_MUL_EN
      run_alu("m_ignored", OP, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7, 5'd8, 1'b1, 32'd13);
`endif

      // Randomised ALU ops against the model.
      for (int i = 0; i < 60; i++) begin
         rt   = opc[$urandom_range(0, 4)];
         rf3  = 3'($urandom);
         rsst = 1'($urandom);
         ra   = $urandom;
         rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
         rwa  = 5'($urandom);
         rwe  = 1'($urandom);
`ifdef EX_MUL_EN
         rm   = (rt == OP && rf3[2]) ? 1'($urandom) : 1'b0;
`else
         rm   = 1'($urandom);
`endif
         run_alu("rand_alu", rt, rf3, rsst, rm, ra, rb, rwa, rwe,
                 model(rt, rf3, rsst, rm, ra, rb));
      end

`ifdef EX_MUL_EN
      run_mul("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0000_0001);
      run_mul("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'hFFFF_FFFE);
      run_mul("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'h0000_0000);
      run_mul("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b0, 32'hFFFF_FFFF);

      // Back-to-back: ADD presented in cycle 33 must not stall.
      run_mul("b2b_mul", 3'd0, 32'd1000, 32'd3, 5'd14, 1'b1, 32'd3000);
      run_alu("b2b_add", OP, 3'd0, 1'b0, 1'b0, 32'd20, 32'd22, 5'd15, 1'b1, 32'd42);

      // DIV/REM encodings return 0 in one cycle.
      run_alu("div_zero", OP, 3'd4, 1'b0, 1'b1, 32'd100, 32'd7, 5'd16, 1'b1, 32'd0);

      for (int i = 0; i < 6; i++) begin
         rf3 = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         rwa = 5'($urandom);
         run_mul("rand_mul", rf3, ra, rb, rwa, 1'b1, model(OP, rf3, 1'b0, 1'b1, ra, rb));
      end

      // Abort at cnt=10 (cycle 11).
      set_in(OP, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b1);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_wd", mem_wd, 32'd0);
      check("abort_we", 32'(mem_we), 32'd0);
      check("abort_wa", 32'(mem_wa), 32'd0);
      check("abort_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      check("abort_hold_we", 32'(mem_we), 32'd0);
      rst = 1'b1;
      run_mul("post_abort", 3'd0, 32'd6, 32'd7, 5'd18, 1'b1, 32'd42);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
